// File: rtl/commit_trace_pkg.sv
// Shared encodings for the commit trace buffer: record types, counter selects
// and the packed record layout {type[1:0], a[15:0], b[15:0]}.
package commit_trace_pkg;

  localparam logic [1:0] TR_REG   = 2'd0;
  localparam logic [1:0] TR_LOAD  = 2'd1;
  localparam logic [1:0] TR_STORE = 2'd2;
  localparam logic [1:0] TR_HALT  = 2'd3;

  localparam logic [2:0] CNT_CYCLES = 3'd0;
  localparam logic [2:0] CNT_INST   = 3'd1;
  localparam logic [2:0] CNT_IHIT   = 3'd2;
  localparam logic [2:0] CNT_IREQ   = 3'd3;
  localparam logic [2:0] CNT_DHIT   = 3'd4;
  localparam logic [2:0] CNT_DREQ   = 3'd5;

  localparam int REC_W = 34;

  function automatic logic [REC_W-1:0] pack_rec(input logic [1:0] t,
                                                input logic [15:0] a,
                                                input logic [15:0] b);
    return {t, a, b};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO; the head is presented combinationally
// and reads as zero while empty.
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = REC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/commit_trace_buf.sv
// Retire-event capture, serializer into a record FIFO, and run performance
// counters for the processor's MEM/WB stage.
module commit_trace_buf
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regWrite,
  input  logic [2:0]       wrReg,
  input  logic [15:0]      wrData,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [15:0]      memAddr,
  input  logic [15:0]      memDataIn,
  input  logic [15:0]      memDataOut,
  input  logic             halt,
  input  logic             iReq,
  input  logic             iHit,
  input  logic             dReq,
  input  logic             dHit,
  output logic             stall,
  output logic             trValid,
  input  logic             trReady,
  output logic [1:0]       trType,
  output logic [15:0]      trA,
  output logic [15:0]      trB,
  input  logic [2:0]       cntSel,
  output logic [CNT_W-1:0] cntData,
  output logic             done
);

  // Pending-event mask bits: [0]=register write, [1]=memory op, [2]=halt.
  logic [2:0]       mask;
  logic [2:0]       clr_bit;
  logic [2:0]       remain;
  logic [2:0]       cap_wr_reg;
  logic [15:0]      cap_wr_data;
  logic [15:0]      cap_addr;
  logic [15:0]      cap_mem_data;
  logic             cap_store;
  logic             halted;
  logic             capture;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [1:0]       rec_type;
  logic [15:0]      rec_a;
  logic [15:0]      rec_b;
  logic [REC_W-1:0] head;
  logic [CNT_W-1:0] cnt_cycles, cnt_inst, cnt_ihit, cnt_ireq, cnt_dhit, cnt_dreq;

  // trValid/trReady: a record transfers on every edge where both are high;
  // while trValid is high and trReady low the head fields hold steady.
  assign pop     = trValid & trReady;
  assign capture = ~stall & ~halted;

  always_comb begin
    rec_type = TR_REG;
    rec_a    = '0;
    rec_b    = '0;
    clr_bit  = '0;
    if (mask[0]) begin
      rec_type = TR_REG;
      rec_a    = {13'b0, cap_wr_reg};
      rec_b    = cap_wr_data;
      clr_bit  = 3'b001;
    end else if (mask[1]) begin
      rec_type = cap_store ? TR_STORE : TR_LOAD;
      rec_a    = cap_addr;
      rec_b    = cap_mem_data;
      clr_bit  = 3'b010;
    end else if (mask[2]) begin
      rec_type = TR_HALT;
      clr_bit  = 3'b100;
    end
  end

  assign push   = (mask != 3'b000) & (~full | pop);
  assign remain = push ? (mask & ~clr_bit) : mask;
  assign stall  = (remain != 3'b000);
  assign done   = halted & (mask == 3'b000) & empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask         <= '0;
      cap_wr_reg   <= '0;
      cap_wr_data  <= '0;
      cap_addr     <= '0;
      cap_mem_data <= '0;
      cap_store    <= 1'b0;
      halted       <= 1'b0;
    end else if (capture) begin
      // remain is zero whenever capture is allowed, so the mask reloads cleanly.
      mask         <= {halt, memRead | memWrite, regWrite};
      cap_wr_reg   <= wrReg;
      cap_wr_data  <= wrData;
      cap_addr     <= memAddr;
      cap_mem_data <= memWrite ? memDataIn : memDataOut;
      cap_store    <= memWrite;
      if (halt) halted <= 1'b1;
    end else begin
      mask <= remain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_cycles <= '0;
      cnt_inst   <= '0;
      cnt_ihit   <= '0;
      cnt_ireq   <= '0;
      cnt_dhit   <= '0;
      cnt_dreq   <= '0;
    end else begin
      if (!halted) cnt_cycles <= cnt_cycles + CNT_W'(1);
      if (capture) begin
        if (halt | regWrite | memWrite) cnt_inst <= cnt_inst + CNT_W'(1);
        if (iHit) cnt_ihit <= cnt_ihit + CNT_W'(1);
        if (iReq) cnt_ireq <= cnt_ireq + CNT_W'(1);
        if (dHit) cnt_dhit <= cnt_dhit + CNT_W'(1);
        if (dReq) cnt_dreq <= cnt_dreq + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cntData = '0;
    case (cntSel)
      CNT_CYCLES: cntData = cnt_cycles;
      CNT_INST:   cntData = cnt_inst;
      CNT_IHIT:   cntData = cnt_ihit;
      CNT_IREQ:   cntData = cnt_ireq;
      CNT_DHIT:   cntData = cnt_dhit;
      CNT_DREQ:   cntData = cnt_dreq;
      default:    cntData = '0;
    endcase
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (pack_rec(rec_type, rec_a, rec_b)),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign trValid = ~empty;
  assign trType  = head[33:32];
  assign trA     = head[31:16];
  assign trB     = head[15:0];

endmodule

// File: tb/tb_commit_trace_buf.sv
// Self-checking bench for commit_trace_buf: directed scenarios plus a random
// phase, scored against a record-queue and counter reference model.
module tb_commit_trace_buf;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  localparam logic [1:0] T_REG   = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_STORE = 2'd2;
  localparam logic [1:0] T_HALT  = 2'd3;

  // clock / reset and DUT signals
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             regWrite = 1'b0;
  logic [2:0]       wrReg = '0;
  logic [15:0]      wrData = '0;
  logic             memRead = 1'b0;
  logic             memWrite = 1'b0;
  logic [15:0]      memAddr = '0;
  logic [15:0]      memDataIn = '0;
  logic [15:0]      memDataOut = '0;
  logic             halt = 1'b0;
  logic             iReq = 1'b0;
  logic             iHit = 1'b0;
  logic             dReq = 1'b0;
  logic             dHit = 1'b0;
  logic             stall;
  logic             trValid;
  logic             trReady = 1'b0;
  logic [1:0]       trType;
  logic [15:0]      trA;
  logic [15:0]      trB;
  logic [2:0]       cntSel = '0;
  logic [CNT_W-1:0] cntData;
  logic             done;

  always #10 clk = ~clk;

  commit_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .regWrite   (regWrite),
    .wrReg      (wrReg),
    .wrData     (wrData),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut),
    .halt       (halt),
    .iReq       (iReq),
    .iHit       (iHit),
    .dReq       (dReq),
    .dHit       (dHit),
    .stall      (stall),
    .trValid    (trValid),
    .trReady    (trReady),
    .trType     (trType),
    .trA        (trA),
    .trB        (trB),
    .cntSel     (cntSel),
    .cntData    (cntData),
    .done       (done)
  );

  // scoreboard and reference model
  int               checks = 0;
  int               errors = 0;
  logic [33:0]      exp_q[$];
  logic             m_halted = 1'b0;
  logic [CNT_W-1:0] m_cnt [6];
  logic             rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_halted = 1'b0;
    for (int k = 0; k < 6; k++) m_cnt[k] = '0;
  endtask

  // Records of one accepted event, in trace-file order, plus counter effects.
  task automatic model_capture();
    if (regWrite) exp_q.push_back({T_REG, 13'b0, wrReg, wrData});
    if (memRead || memWrite)
      exp_q.push_back(memWrite ? {T_STORE, memAddr, memDataIn} : {T_LOAD, memAddr, memDataOut});
    if (halt) begin
      exp_q.push_back({T_HALT, 32'h0});
      m_halted = 1'b1;
    end
    if (halt || regWrite || memWrite) m_cnt[1] = m_cnt[1] + 32'd1;
    if (iHit) m_cnt[2] = m_cnt[2] + 32'd1;
    if (iReq) m_cnt[3] = m_cnt[3] + 32'd1;
    if (dHit) m_cnt[4] = m_cnt[4] + 32'd1;
    if (dReq) m_cnt[5] = m_cnt[5] + 32'd1;
  endtask

  // driver tasks
  task automatic idle();
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    halt     = 1'b0;
    iReq     = 1'b0;
    iHit     = 1'b0;
    dReq     = 1'b0;
    dHit     = 1'b0;
  endtask

  // One clock: sample at negedge, score, advance model, return at posedge+1.
  task automatic do_cycle(output logic acc, output logic st);
    @(negedge clk);
    st = stall;
    chk("done", done, (m_halted && exp_q.size() == 0));
    if (exp_q.size() == 0) begin
      chk("rec_extra", trValid, 1'b0);
    end else if (trValid) begin
      chk("rec", {trType, trA, trB}, exp_q[0]);
      if (trReady) void'(exp_q.pop_front());
    end
    acc = !st && !m_halted;
    if (!m_halted) m_cnt[0] = m_cnt[0] + 32'd1;
    if (acc) model_capture();
    @(posedge clk);
    #1;
    if (rand_ready) trReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic hold_until_accepted(output int waits);
    logic acc, st;
    waits = 0;
    do_cycle(acc, st);
    while (!acc && !m_halted && waits < 200) begin
      waits++;
      do_cycle(acc, st);
    end
    if (!acc && !m_halted) chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc, st;
    int n;
    n = 0;
    rand_ready = 1'b0;
    trReady = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      do_cycle(acc, st);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    do_cycle(acc, st);
  endtask

  task automatic check_cnt(input logic [2:0] sel, input logic [CNT_W-1:0] exp, input string tag);
    cntSel = sel;
    #1;
    chk(tag, cntData, exp);
  endtask

  task automatic check_all_cnt(input string tag);
    for (int s = 0; s < 8; s++) begin
      check_cnt(3'(s), (s < 6) ? m_cnt[s] : '0, tag);
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    rand_ready = 1'b0;
    trReady = 1'b0;
    idle();
    #1;
    chk("rst_valid", trValid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rec", {trType, trA, trB}, 34'h0);
    for (int s = 0; s < 8; s++) begin
      cntSel = 3'(s);
      #1;
      chk("rst_cnt", cntData, '0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, st;
    int w, nst, r;
    logic [CNT_W-1:0] inst0;

    apply_reset();

    // single register write, reader stalled to observe latency
    regWrite = 1'b1; wrReg = 3'd3; wrData = 16'h1234;
    hold_until_accepted(w);
    idle();
    chk("single_no_wait", w, 0);
    chk("single_latency_n", trValid, 1'b0);
    do_cycle(acc, st);
    chk("single_stall", st, 1'b0);
    chk("single_valid", trValid, 1'b1);
    chk("single_type", trType, T_REG);
    chk("single_a", trA, 16'h0003);
    chk("single_b", trB, 16'h1234);
    check_cnt(3'd1, 32'd1, "single_inst");
    drain();

    // memRead and memWrite together -> exactly one STORE
    trReady = 1'b1;
    inst0 = m_cnt[1];
    memRead = 1'b1; memWrite = 1'b1; memAddr = 16'h0010;
    memDataIn = 16'h0F0F; memDataOut = 16'h5555;
    hold_until_accepted(w);
    idle();
    do_cycle(acc, st);
    chk("both_valid", trValid, 1'b1);
    chk("both_rec", {trType, trA, trB}, {T_STORE, 16'h0010, 16'h0F0F});
    do_cycle(acc, st);
    chk("both_single", trValid, 1'b0);
    check_cnt(3'd1, inst0 + 32'd1, "both_inst");

    // triple event ending the run
    regWrite = 1'b1; wrReg = 3'd5; wrData = 16'hAAAA;
    memRead = 1'b1; memAddr = 16'h0040; memDataOut = 16'hBEEF;
    halt = 1'b1;
    hold_until_accepted(w);
    idle();
    chk("triple_no_wait", w, 0);
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      do_cycle(acc, st);
      if (st) nst++;
    end
    chk("triple_stall_cycles", nst, 2);
    drain();
    chk("triple_done", done, 1'b1);
    check_cnt(3'd0, m_cnt[0], "cycles_frozen_a");
    regWrite = 1'b1; wrReg = 3'd1; wrData = 16'hDEAD;
    repeat (4) do_cycle(acc, st);
    idle();
    check_cnt(3'd0, m_cnt[0], "cycles_frozen_b");
    check_cnt(3'd1, m_cnt[1], "inst_frozen");

    // backpressure: DEPTH+2 stores with the reader stalled
    apply_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      memWrite = 1'b1; memAddr = 16'(i); memDataIn = ~16'(i);
      hold_until_accepted(w);
      chk("bp_accept", w, 0);
    end
    memWrite = 1'b1; memAddr = 16'(DEPTH + 1); memDataIn = ~16'(DEPTH + 1);
    do_cycle(acc, st);
    chk("bp_stall", st, 1'b1);
    chk("bp_not_taken", acc, 1'b0);
    chk("bp_full_head", {trType, trA, trB}, {T_STORE, 16'h0000, 16'hFFFF});
    trReady = 1'b1;
    hold_until_accepted(w);
    idle();
    drain();

    // performance counters
    apply_reset();
    trReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iReq = 1'b1; iHit = (i < 7); dReq = (i < 3);
      hold_until_accepted(w);
      idle();
    end
    halt = 1'b1;
    hold_until_accepted(w);
    idle();
    check_cnt(3'd3, 32'd10, "cnt_ireq");
    check_cnt(3'd2, 32'd7,  "cnt_ihit");
    check_cnt(3'd5, 32'd3,  "cnt_dreq");
    check_cnt(3'd4, 32'd0,  "cnt_dhit");
    check_cnt(3'd1, 32'd1,  "cnt_inst");
    check_cnt(3'd0, 32'd11, "cnt_cycles");
    check_cnt(3'd6, 32'd0,  "cnt_sel6");
    check_cnt(3'd7, 32'd0,  "cnt_sel7");
    drain();

    // randomized traffic with a random reader
    apply_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      regWrite   = 1'($urandom_range(0, 1));
      wrReg      = 3'($urandom);
      wrData     = 16'($urandom);
      r          = $urandom_range(0, 3);
      memRead    = (r == 1) || (r == 3);
      memWrite   = (r == 2) || (r == 3);
      memAddr    = 16'($urandom);
      memDataIn  = 16'($urandom);
      memDataOut = 16'($urandom);
      iReq       = 1'($urandom_range(0, 1));
      iHit       = iReq & 1'($urandom_range(0, 1));
      dReq       = 1'($urandom_range(0, 1));
      dHit       = dReq & 1'($urandom_range(0, 1));
      hold_until_accepted(w);
      idle();
      if ($urandom_range(0, 3) == 0) do_cycle(acc, st);
    end
    regWrite = 1'b1; wrReg = 3'd7; wrData = 16'h7777; halt = 1'b1;
    hold_until_accepted(w);
    idle();
    drain();
    chk("rand_done", done, 1'b1);
    check_all_cnt("rand_cnt");

    // reset while records are still queued
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      regWrite = 1'b1; wrReg = 3'(i); wrData = 16'($urandom);
      hold_until_accepted(w);
      idle();
    end
    repeat (3) do_cycle(acc, st);
    chk("mid_valid_before", trValid, 1'b1);
    check_cnt(3'd0, m_cnt[0], "mid_cycles_before");
    #2;
    apply_reset();
    repeat (2) do_cycle(acc, st);
    chk("mid_after_valid", trValid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
